// File: rtl/pulse_pkg.sv
// Shared types and sizing for the pulse sequencer and its command FIFO.
package pulse_pkg;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned AMP_W   = 8;
    localparam int unsigned DELAY_W = 8;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AMP_W-1:0]   amp;
        logic [DELAY_W-1:0] delay;
    } pulse_cmd_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_WAIT,
        SEQ_FIRE,
        SEQ_HOLD
    } seq_state_t;

endpackage

// File: rtl/pulse_cmd_fifo.sv
// Synchronous show-ahead FIFO of pulse commands with synchronous clear.
module pulse_cmd_fifo
    import pulse_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  pulse_cmd_t       wr_data,
    output pulse_cmd_t       rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    pulse_cmd_t       mem_q [DEPTH];
    pulse_cmd_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Pointer wrap relies on DEPTH being a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pulse_sequencer.sv
// Queues timed pulse commands and issues one trigger per command to the pulse
// controller, using pulse_active as back-pressure.
module pulse_sequencer
    import pulse_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [AMP_W-1:0]   cmd_amp,
    input  logic [DELAY_W-1:0] cmd_delay,
    input  logic               run,
    input  logic               abort,
    input  logic               pulse_active,
    output logic               trigger,
    output logic [AMP_W-1:0]   amplitude,
    output logic               busy,
    output logic [CNT_W-1:0]   fifo_count,
    output logic               pulse_done
);

    seq_state_t         state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [AMP_W-1:0]   amp_q, amp_d;
    logic               done_q, done_d;

    pulse_cmd_t         wr_cmd;
    pulse_cmd_t         head_cmd;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;

    assign wr_cmd.amp   = cmd_amp;
    assign wr_cmd.delay = cmd_delay;

    // Abort drops any push and pop in the same cycle along with the queue.
    assign fifo_push = cmd_valid && !fifo_full && !abort;
    assign fifo_pop  = (state_q == SEQ_IDLE) && run && !fifo_empty && !abort;

    pulse_cmd_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .clear   (abort),
        .wr_data (wr_cmd),
        .rd_data (head_cmd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign cmd_ready  = !fifo_full;
    assign busy       = (state_q != SEQ_IDLE);
    assign amplitude  = amp_q;
    assign pulse_done = done_q;
    assign trigger    = (state_q == SEQ_FIRE) && !pulse_active && !abort;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        amp_d   = amp_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = SEQ_IDLE;
            cnt_d   = '0;
            amp_d   = '0;
        end else begin
            unique case (state_q)
                SEQ_IDLE: begin
                    if (fifo_pop) begin
                        cnt_d   = head_cmd.delay;
                        amp_d   = head_cmd.amp;
                        state_d = SEQ_WAIT;
                    end
                end
                SEQ_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = SEQ_FIRE;
                    end else begin
                        cnt_d = cnt_q - DELAY_W'(1);
                    end
                end
                // Hold off the trigger while a previous pulse is still running.
                SEQ_FIRE: begin
                    if (!pulse_active) begin
                        state_d = SEQ_HOLD;
                    end
                end
                SEQ_HOLD: begin
                    if (!pulse_active) begin
                        done_d  = 1'b1;
                        amp_d   = '0;
                        state_d = SEQ_IDLE;
                    end
                end
                default: state_d = SEQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
            cnt_q   <= '0;
            amp_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            amp_q   <= amp_d;
            done_q  <= done_d;
        end
    end

endmodule
